// File: rtl/mimo_channel_tx_if.sv
// Handshake and data bus between the stimulus source, mimo_channel_tx and the detector.
// The slave modport is the mimo_channel_tx side; master is the upstream/downstream side.
interface mimo_channel_tx_if #(
  parameter int WL = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     X_i;
  logic [WL*64-1:0] Hmatrix_i;
  logic [WL*8-1:0] Narray_i;
  logic            out_valid;
  logic            out_ready;
  logic [WL*8-1:0] Yarray_o;
  logic [15:0]     X_o;

  modport master (
    output in_valid, X_i, Hmatrix_i, Narray_i, out_ready,
    input  in_ready, out_valid, Yarray_o, X_o
  );

  modport slave (
    input  in_valid, X_i, Hmatrix_i, Narray_i, out_ready,
    output in_ready, out_valid, Yarray_o, X_o
  );
endinterface

// File: rtl/mimo_channel_tx.sv
// Builds y = H*s + n for a 4x4 16QAM MIMO link, one row per cycle, with saturation to WL bits.
// Symbols are Gray-mapped to {-3,-1,+1,+3}; products use shift-and-add instead of multipliers.
module mimo_channel_tx #(
  parameter int WL = 16
) (
  input logic clk,
  input logic rst_n,
  mimo_channel_tx_if.slave bus
);

  localparam int SW = WL + 5;
  localparam logic signed [SW-1:0] SatMax = {{6{1'b0}}, {(WL-1){1'b1}}};
  localparam logic signed [SW-1:0] SatMin = {{6{1'b1}}, {(WL-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           rowCnt_q, rowCnt_d;
  logic [15:0]          xReg_q;
  logic signed [WL-1:0] hReg_q [8][8];
  logic signed [WL-1:0] nReg_q [8];
  logic [WL*7-1:0]      yBuf_q;
  logic [WL*8-1:0]      yOut_q;
  logic [15:0]          xOut_q;

  logic                 captureEn;
  logic                 rowEn;
  logic                 resultLoad;
  logic [1:0]           symBits [8];
  logic signed [SW-1:0] rowSum;
  logic signed [WL-1:0] rowSat;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Yarray_o  = yOut_q;
  assign bus.X_o       = xOut_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rowCnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      rowCnt_q <= rowCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rowCnt_d   = rowCnt_q;
    captureEn  = 1'b0;
    rowEn      = 1'b0;
    resultLoad = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          captureEn = 1'b1;
          rowCnt_d  = 3'd0;
          state_d   = CALC;
        end
      end
      CALC: begin
        rowEn    = 1'b1;
        rowCnt_d = rowCnt_q + 3'd1;
        if (rowCnt_q == 3'd7) begin
          resultLoad = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Real-valued ordering: entries 0..3 carry the I bits, entries 4..7 the Q bits.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      symBits[k]     = xReg_q[4*k+2 +: 2];
      symBits[k + 4] = xReg_q[4*k +: 2];
    end
  end

  // Bit 1 of a Gray level gives the sign, bit 0 clear selects magnitude 3 (H + 2H).
  always_comb begin
    logic signed [SW-1:0] hExt;
    logic signed [SW-1:0] hMag;
    hExt   = '0;
    hMag   = '0;
    rowSum = {{5{nReg_q[rowCnt_q][WL-1]}}, nReg_q[rowCnt_q]};
    for (int c = 0; c < 8; c++) begin
      hExt = {{5{hReg_q[rowCnt_q][c][WL-1]}}, hReg_q[rowCnt_q][c]};
      hMag = symBits[c][0] ? hExt : (hExt + (hExt <<< 1));
      rowSum = symBits[c][1] ? (rowSum + hMag) : (rowSum - hMag);
    end
    if (rowSum > SatMax) begin
      rowSat = SatMax[WL-1:0];
    end else if (rowSum < SatMin) begin
      rowSat = SatMin[WL-1:0];
    end else begin
      rowSat = rowSum[WL-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xReg_q <= '0;
      yBuf_q <= '0;
      yOut_q <= '0;
      xOut_q <= '0;
      for (int r = 0; r < 8; r++) begin
        nReg_q[r] <= '0;
        for (int c = 0; c < 8; c++) begin
          hReg_q[r][c] <= '0;
        end
      end
    end else begin
      if (captureEn) begin
        xReg_q <= bus.X_i;
        for (int r = 0; r < 8; r++) begin
          nReg_q[r] <= bus.Narray_i[r*WL +: WL];
          for (int c = 0; c < 8; c++) begin
            hReg_q[r][c] <= bus.Hmatrix_i[r*8*WL + c*WL +: WL];
          end
        end
      end
      for (int r = 0; r < 7; r++) begin
        if (rowEn && (rowCnt_q == 3'(r))) begin
          yBuf_q[r*WL +: WL] <= rowSat;
        end
      end
      // Row 7 goes straight to the output so the whole vector appears on one edge.
      if (resultLoad) begin
        yOut_q <= {rowSat, yBuf_q};
        xOut_q <= xReg_q;
      end
    end
  end

endmodule

// File: tb/tb_mimo_channel_tx.sv
// Self-checking bench for mimo_channel_tx: directed corner cases plus a random stream
// compared against an integer-arithmetic reference of y = H*s + n with saturation.
module tb_mimo_channel_tx;

  localparam int WL = 16;

  typedef logic [WL*64-1:0] hmat_t;
  typedef logic [WL*8-1:0]  vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;

  mimo_channel_tx_if #(.WL(WL)) bus();

  mimo_channel_tx #(.WL(WL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int levelOf(input logic [1:0] bits);
    case (bits)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  function automatic vec_t refModel(input logic [15:0] x, input hmat_t h, input vec_t n);
    int   s [8];
    int   acc;
    vec_t y;
    for (int k = 0; k < 4; k++) begin
      s[k]     = levelOf(x[4*k+3 -: 2]);
      s[k + 4] = levelOf(x[4*k+1 -: 2]);
    end
    for (int r = 0; r < 8; r++) begin
      acc = $signed(n[r*WL +: WL]);
      for (int c = 0; c < 8; c++) begin
        acc = acc + $signed(h[r*8*WL + c*WL +: WL]) * s[c];
      end
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      y[r*WL +: WL] = acc[WL-1:0];
    end
    return y;
  endfunction

  function automatic vec_t packRows(input int rows [8]);
    vec_t v;
    for (int r = 0; r < 8; r++) begin
      v[r*WL +: WL] = rows[r][WL-1:0];
    end
    return v;
  endfunction

  function automatic hmat_t diagH(input int value);
    hmat_t h;
    h = '0;
    for (int r = 0; r < 8; r++) begin
      h[r*8*WL + r*WL +: WL] = value[WL-1:0];
    end
    return h;
  endfunction

  function automatic hmat_t fillH(input logic [WL-1:0] value);
    hmat_t h;
    for (int i = 0; i < 64; i++) begin
      h[i*WL +: WL] = value;
    end
    return h;
  endfunction

  task automatic genRandom(output logic [15:0] x, output hmat_t h, output vec_t n);
    logic [WL-1:0] w;
    int shift;
    x = 16'($urandom);
    shift = $urandom_range(0, 3) * 2;
    for (int i = 0; i < 64; i++) begin
      w = WL'($urandom);
      h[i*WL +: WL] = WL'($signed(w) >>> shift);
    end
    for (int r = 0; r < 8; r++) begin
      n[r*WL +: WL] = WL'($urandom);
    end
  endtask

  // Present a vector, wait (bounded) for acceptance, then drop in_valid just after the capture edge.
  task automatic applyStimulus(input logic [15:0] x, input hmat_t h, input vec_t n);
    int waitCycles;
    bus.X_i       = x;
    bus.Hmatrix_i = h;
    bus.Narray_i  = n;
    bus.in_valid  = 1'b1;
    waitCycles = 0;
    while (!bus.in_ready && waitCycles < 100) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", 128'(bus.in_ready), 128'(1));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output int latency);
    latency = 0;
    while (!bus.out_valid && latency < 50) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic consumeResult();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
    checkOutput({tag, "_yarray"}, 128'(bus.Yarray_o), 128'(0));
    checkOutput({tag, "_x_o"}, 128'(bus.X_o), 128'(0));
    checkOutput({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
  endtask

  int identityRows [8] = '{300, -300, 100, -100, 300, -300, 100, -100};
  int noiseRows    [8] = '{-4, -3, -2, -1, 0, 1, 2, 3};

  initial begin
    logic [15:0] x;
    hmat_t       h;
    vec_t        n;
    vec_t        expY;
    int          lat;
    vec_t        expQ [$];
    logic [15:0] expXQ [$];
    int          sent;
    int          received;
    int          cyc;
    int          lastOut;
    logic        prevReady;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.X_i       = '0;
    bus.Hmatrix_i = '0;
    bus.Narray_i  = '0;

    // Reset state, including a pulsed in_valid that must not be captured.
    #2;
    bus.in_valid = 1'b1;
    checkResetState("reset");
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkResetState("reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_no_capture", 128'(bus.in_ready), 128'(1));

    // Identity channel.
    applyStimulus(16'h5F0A, diagH(100), '0);
    waitResult(lat);
    checkOutput("identity_latency", 128'(lat), 128'(8));
    checkOutput("identity_y", 128'(bus.Yarray_o), 128'(packRows(identityRows)));
    checkOutput("identity_x", 128'(bus.X_o), 128'(16'h5F0A));
    consumeResult();
    checkOutput("identity_in_ready_after", 128'(bus.in_ready), 128'(1));
    checkOutput("identity_y_kept", 128'(bus.Yarray_o), 128'(packRows(identityRows)));

    // Positive and negative saturation.
    applyStimulus(16'hAAAA, fillH(16'h7FFF), '0);
    waitResult(lat);
    checkOutput("sat_pos_y", 128'(bus.Yarray_o), {8{16'h7FFF}});
    consumeResult();
    applyStimulus(16'hAAAA, fillH(16'h8000), '0);
    waitResult(lat);
    checkOutput("sat_neg_y", 128'(bus.Yarray_o), {8{16'h8000}});
    consumeResult();

    // Noise-only path and noise-driven saturation.
    applyStimulus(16'h1234, '0, packRows(noiseRows));
    waitResult(lat);
    checkOutput("noise_y", 128'(bus.Yarray_o), 128'(packRows(noiseRows)));
    consumeResult();
    h = '0;
    h[0 +: WL] = 16'd1;
    n = '0;
    n[0 +: WL] = 16'h7FFF;
    applyStimulus(16'h000F, h, n);
    waitResult(lat);
    checkOutput("noise_sat_y", 128'(bus.Yarray_o), 128'(refModel(16'h000F, h, n)));
    checkOutput("noise_sat_y0", 128'(bus.Yarray_o[15:0]), 128'(16'h7FFF));
    consumeResult();

    // Backpressure: output held for 20 cycles, pulsed input ignored.
    genRandom(x, h, n);
    expY = refModel(x, h, n);
    applyStimulus(x, h, n);
    waitResult(lat);
    checkOutput("bp_latency", 128'(lat), 128'(8));
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus.X_i      = 16'h1234;
        bus.in_valid = 1'b1;
      end
      if (i == 6) bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", 128'(bus.out_valid), 128'(1));
      checkOutput("bp_in_ready", 128'(bus.in_ready), 128'(0));
      checkOutput("bp_y", 128'(bus.Yarray_o), 128'(expY));
      checkOutput("bp_x", 128'(bus.X_o), 128'(x));
    end
    consumeResult();
    checkOutput("bp_release_in_ready", 128'(bus.in_ready), 128'(1));
    checkOutput("bp_release_out_valid", 128'(bus.out_valid), 128'(0));
    repeat (10) @(posedge clk);
    #1;
    checkOutput("bp_pulse_not_captured", 128'(bus.out_valid), 128'(0));
    checkOutput("bp_y_kept", 128'(bus.Yarray_o), 128'(expY));

    // Reset in the middle of CALC at row 4.
    genRandom(x, h, n);
    applyStimulus(x, h, n);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetState("midcalc_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(16'h5F0A, diagH(100), '0);
    waitResult(lat);
    checkOutput("post_reset_latency", 128'(lat), 128'(8));
    checkOutput("post_reset_y", 128'(bus.Yarray_o), 128'(packRows(identityRows)));
    checkOutput("post_reset_x", 128'(bus.X_o), 128'(16'h5F0A));
    consumeResult();

    // Streaming: in_valid held high, out_ready tied high.
    bus.out_ready = 1'b1;
    genRandom(x, h, n);
    bus.X_i       = x;
    bus.Hmatrix_i = h;
    bus.Narray_i  = n;
    bus.in_valid  = 1'b1;
    expQ.push_back(refModel(x, h, n));
    expXQ.push_back(x);
    sent      = 1;
    received  = 0;
    cyc       = 0;
    lastOut   = -1;
    prevReady = bus.in_ready;
    while (received < 200 && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (prevReady && bus.in_valid) begin
        if (sent < 200) begin
          genRandom(x, h, n);
          bus.X_i       = x;
          bus.Hmatrix_i = h;
          bus.Narray_i  = n;
          expQ.push_back(refModel(x, h, n));
          expXQ.push_back(x);
          sent++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("stream_unexpected", 128'(bus.out_valid), 128'(0));
        end else begin
          checkOutput("stream_y", 128'(bus.Yarray_o), 128'(expQ.pop_front()));
          checkOutput("stream_x", 128'(bus.X_o), 128'(expXQ.pop_front()));
        end
        if (lastOut >= 0) begin
          checkOutput("stream_interval", 128'(cyc - lastOut), 128'(10));
        end
        lastOut = cyc;
        received++;
      end
      prevReady = bus.in_ready;
    end
    checkOutput("stream_count", 128'(received), 128'(200));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
